pipe_ctrl_unit: RTL and testbench

Parametrised successor to the single-cycle opcode decoder for the 16-bit pipelined CPU.
- Decodes the ID-stage opcode into a control bundle and carries that bundle, plus the destination register, through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and generates the stall, bubble and flush behaviour for the front end.
- Sequences HALT with a drain state machine.

---
 rtl/pipe_ctrl_unit_if.sv | 43 ++++
 rtl/pipe_ctrl_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_unit_if.sv
// Front-end bundle of the pipeline control unit: ID-stage fields and flush in,
// per-stage control fields, hazard enables and status out.
interface pipe_ctrl_unit_if #(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 4,
    parameter int REG_AW   = 3
);
    logic                id_valid;
    logic [OPCODE_W-1:0] id_opcode;
    logic [REG_AW-1:0]   id_rd;
    logic [REG_AW-1:0]   id_rs1;
    logic [REG_AW-1:0]   id_rs2;
    logic                ex_flush;

    logic                pc_write;
    logic                ifid_write;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic                ex_alu_src_imm;
    logic                ex_branch;
    logic [REG_AW-1:0]   ex_rd;
    logic                mem_read;
    logic                mem_write;
    logic [REG_AW-1:0]   mem_rd;
    logic                wb_reg_write;
    logic                wb_mem_to_reg;
    logic [REG_AW-1:0]   wb_rd;
    logic                illegal_op;
    logic                halted;

    modport master (
        output id_valid, id_opcode, id_rd, id_rs1, id_rs2, ex_flush,
        input  pc_write, ifid_write, ex_alu_op, ex_alu_src_imm, ex_branch, ex_rd,
               mem_read, mem_write, mem_rd, wb_reg_write, wb_mem_to_reg, wb_rd,
               illegal_op, halted
    );

    modport slave (
        input  id_valid, id_opcode, id_rd, id_rs1, id_rs2, ex_flush,
        output pc_write, ifid_write, ex_alu_op, ex_alu_src_imm, ex_branch, ex_rd,
               mem_read, mem_write, mem_rd, wb_reg_write, wb_mem_to_reg, wb_rd,
               illegal_op, halted
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit for the 16-bit CPU: opcode decode, ID/EX-EX/MEM-MEM/WB
// control registers, load-use stall, branch flush and HALT drain sequencing.
module pipe_ctrl_unit #(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 4,
    parameter int REG_AW   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_ctrl_unit_if.slave    bus
);

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src_imm;
        logic                branch;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                mem_to_reg;
        logic [REG_AW-1:0]   rd;
    } id_ex_t;

    typedef struct packed {
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                mem_to_reg;
        logic [REG_AW-1:0]   rd;
    } ex_mem_t;

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic [REG_AW-1:0]   rd;
    } mem_wb_t;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [1:0] DRAIN_LAST = 2'd2;

    function automatic logic [ALU_OP_W-1:0] alu_code(input logic [2:0] code);
        return ALU_OP_W'(code);
    endfunction

    state_t            state_reg, state_next;
    logic [1:0]        cnt_reg, cnt_next;
    id_ex_t            id_ex_reg, id_ex_next;
    ex_mem_t           ex_mem_reg, ex_mem_next;
    mem_wb_t           mem_wb_reg, mem_wb_next;
    logic              illegal_reg, illegal_next;

    logic [3:0]        op_lo;
    logic              op_upper_set;
    id_ex_t            dec;
    logic              dec_illegal;
    logic              dec_halt;
    logic [1:0]        src_used;
    logic [1:0]        src_match;
    logic [REG_AW-1:0] src_addr [2];
    logic              stall;
    logic              pc_write_c;
    logic              ifid_write_c;

    assign op_lo = bus.id_opcode[3:0];

    generate
        if (OPCODE_W > 4) begin : g_upper
            assign op_upper_set = |bus.id_opcode[OPCODE_W-1:4];
        end else begin : g_no_upper
            assign op_upper_set = 1'b0;
        end
    endgenerate

    // src_used[0] marks rs1 as read, src_used[1] marks rs2 as read.
    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        dec_halt    = 1'b0;
        src_used    = 2'b00;
        if (op_upper_set) begin
            dec_illegal = 1'b1;
        end else begin
            case (op_lo)
                OP_ADD:  begin dec.alu_op = alu_code(3'd0); dec.reg_write = 1'b1; src_used = 2'b11; end
                OP_SUB:  begin dec.alu_op = alu_code(3'd1); dec.reg_write = 1'b1; src_used = 2'b11; end
                OP_AND:  begin dec.alu_op = alu_code(3'd2); dec.reg_write = 1'b1; src_used = 2'b11; end
                OP_OR:   begin dec.alu_op = alu_code(3'd3); dec.reg_write = 1'b1; src_used = 2'b11; end
                OP_XOR:  begin dec.alu_op = alu_code(3'd4); dec.reg_write = 1'b1; src_used = 2'b11; end
                OP_SLT:  begin dec.alu_op = alu_code(3'd5); dec.reg_write = 1'b1; src_used = 2'b11; end
                OP_ADDI: begin
                    dec.alu_op      = alu_code(3'd0);
                    dec.alu_src_imm = 1'b1;
                    dec.reg_write   = 1'b1;
                    src_used        = 2'b01;
                end
                OP_LW: begin
                    dec.alu_op      = alu_code(3'd0);
                    dec.alu_src_imm = 1'b1;
                    dec.mem_read    = 1'b1;
                    dec.reg_write   = 1'b1;
                    dec.mem_to_reg  = 1'b1;
                    src_used        = 2'b01;
                end
                OP_SW: begin
                    dec.alu_op      = alu_code(3'd0);
                    dec.alu_src_imm = 1'b1;
                    dec.mem_write   = 1'b1;
                    src_used        = 2'b11;
                end
                OP_BEQ: begin
                    dec.alu_op = alu_code(3'd1);
                    dec.branch = 1'b1;
                    src_used   = 2'b11;
                end
                OP_HALT: dec_halt = 1'b1;
                default: dec_illegal = 1'b1;
            endcase
        end
        dec.rd = bus.id_rd;
    end

    assign src_addr[0] = bus.id_rs1;
    assign src_addr[1] = bus.id_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_used[gi] && (id_ex_reg.rd == src_addr[gi]);
        end
    endgenerate

    // Register 0 is hard-wired to zero, so a load targeting it never blocks.
    assign stall = bus.id_valid && id_ex_reg.mem_read &&
                   (id_ex_reg.rd != '0) && (|src_match);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        id_ex_next   = '0;
        illegal_next = illegal_reg;
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        case (state_reg)
            S_RUN: begin
                if (bus.ex_flush) begin
                    pc_write_c   = 1'b1;
                    ifid_write_c = 1'b1;
                end else if (!stall) begin
                    pc_write_c   = 1'b1;
                    ifid_write_c = 1'b1;
                    if (bus.id_valid) begin
                        if (dec_illegal) begin
                            illegal_next = 1'b1;
                        end else if (dec_halt) begin
                            state_next = S_DRAIN;
                            cnt_next   = 2'd0;
                        end else begin
                            id_ex_next = dec;
                        end
                    end
                end
            end
            // Front end is frozen after HALT; whatever sits in ID is not executed.
            S_DRAIN: begin
                if (cnt_reg == DRAIN_LAST) begin
                    state_next = S_HALTED;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    always_comb begin
        ex_mem_next.mem_read   = id_ex_reg.mem_read;
        ex_mem_next.mem_write  = id_ex_reg.mem_write;
        ex_mem_next.reg_write  = id_ex_reg.reg_write;
        ex_mem_next.mem_to_reg = id_ex_reg.mem_to_reg;
        ex_mem_next.rd         = id_ex_reg.rd;
        mem_wb_next.reg_write  = ex_mem_reg.reg_write;
        mem_wb_next.mem_to_reg = ex_mem_reg.mem_to_reg;
        mem_wb_next.rd         = ex_mem_reg.rd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_RUN;
            cnt_reg     <= 2'd0;
            id_ex_reg   <= '0;
            ex_mem_reg  <= '0;
            mem_wb_reg  <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            id_ex_reg   <= id_ex_next;
            ex_mem_reg  <= ex_mem_next;
            mem_wb_reg  <= mem_wb_next;
            illegal_reg <= illegal_next;
        end
    end

    assign bus.pc_write       = rst_n && pc_write_c;
    assign bus.ifid_write     = rst_n && ifid_write_c;
    assign bus.ex_alu_op      = id_ex_reg.alu_op;
    assign bus.ex_alu_src_imm = id_ex_reg.alu_src_imm;
    assign bus.ex_branch      = id_ex_reg.branch;
    assign bus.ex_rd          = id_ex_reg.rd;
    assign bus.mem_read       = ex_mem_reg.mem_read;
    assign bus.mem_write      = ex_mem_reg.mem_write;
    assign bus.mem_rd         = ex_mem_reg.rd;
    assign bus.wb_reg_write   = mem_wb_reg.reg_write;
    assign bus.wb_mem_to_reg  = mem_wb_reg.mem_to_reg;
    assign bus.wb_rd          = mem_wb_reg.rd;
    assign bus.illegal_op     = illegal_reg;
    assign bus.halted         = (state_reg == S_HALTED);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: each driven ID instruction pushes its
// expected control bundle, which is popped as it emerges from EX, MEM and WB.
module tb_pipe_ctrl_unit;

    typedef struct packed {
        logic [3:0] alu;
        logic       imm;
        logic       br;
        logic       mr;
        logic       mw;
        logic       rw;
        logic       m2r;
        logic [2:0] rd;
    } bundle_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.OPCODE_W(4), .ALU_OP_W(4), .REG_AW(3)) bus ();

    pipe_ctrl_unit #(.OPCODE_W(4), .ALU_OP_W(4), .REG_AW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int      n_checks = 0;
    int      n_fail   = 0;
    bundle_t ex_q[$];
    bundle_t mem_q[$];
    bundle_t wb_q[$];

    int      m_state;
    int      m_cnt;
    logic    m_ill;
    bundle_t m_ex;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bundle_t ref_decode(input logic [3:0] op, input logic [2:0] rd);
        bundle_t b;
        b = '0;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin b.alu = op; b.rw = 1'b1; end
            4'd6: begin b.imm = 1'b1; b.rw = 1'b1; end
            4'd7: begin b.imm = 1'b1; b.mr = 1'b1; b.rw = 1'b1; b.m2r = 1'b1; end
            4'd8: begin b.imm = 1'b1; b.mw = 1'b1; end
            4'd9: begin b.alu = 4'd1; b.br = 1'b1; end
            default: ;
        endcase
        b.rd = rd;
        return b;
    endfunction

    function automatic bundle_t pop_or_bubble(inout bundle_t q[$]);
        if (q.size() == 0) return '0;
        return q.pop_front();
    endfunction

    task automatic step(input logic v, input logic [3:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2, input logic fl,
                        output logic stalled);
        bundle_t nb;
        bundle_t e;
        logic    u1, u2, st, legal, exp_pc;
        nb = '0;
        @(negedge clk);
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_rd     = rd;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
        bus.ex_flush  = fl;
        u1    = (op <= 4'd9);
        u2    = (op <= 4'd5) || (op == 4'd8) || (op == 4'd9);
        st    = v && m_ex.mr && (m_ex.rd != 3'd0) &&
                ((u1 && m_ex.rd == rs1) || (u2 && m_ex.rd == rs2));
        legal = (op <= 4'd9) || (op == 4'd15);
        stalled = 1'b0;
        if (m_state == 0) begin
            exp_pc  = fl || !st;
            stalled = !fl && st;
            if (v && !fl && !st) begin
                if (!legal) m_ill = 1'b1;
                else if (op == 4'd15) begin m_state = 1; m_cnt = 0; end
                else nb = ref_decode(op, rd);
            end
        end else begin
            exp_pc = 1'b0;
            if (m_state == 1) begin
                if (m_cnt == 2) m_state = 2;
                else m_cnt++;
            end
        end
        #1;
        check_eq("pc_ifid_write", {bus.pc_write, bus.ifid_write}, {exp_pc, exp_pc});
        ex_q.push_back(nb);
        mem_q.push_back(nb);
        wb_q.push_back(nb);
        m_ex = nb;
        @(posedge clk);
        #1;
        e = pop_or_bubble(ex_q);
        check_eq("ex_bundle", {bus.ex_alu_op, bus.ex_alu_src_imm, bus.ex_branch, bus.ex_rd},
                 {e.alu, e.imm, e.br, e.rd});
        e = pop_or_bubble(mem_q);
        check_eq("mem_bundle", {bus.mem_read, bus.mem_write, bus.mem_rd}, {e.mr, e.mw, e.rd});
        e = pop_or_bubble(wb_q);
        check_eq("wb_bundle", {bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_rd}, {e.rw, e.m2r, e.rd});
        check_eq("illegal_op", bus.illegal_op, m_ill);
        check_eq("halted", bus.halted, (m_state == 2));
        $display("step v=%0d op=%0d rd=%0d rs1=%0d rs2=%0d flush=%0d pc_write=%0d ex_rd=%0d wb_rd=%0d halted=%0d",
                 v, op, rd, rs1, rs2, fl, exp_pc, bus.ex_rd, bus.wb_rd, bus.halted);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.id_valid  = 1'b0;
        bus.id_opcode = '0;
        bus.id_rd     = '0;
        bus.id_rs1    = '0;
        bus.id_rs2    = '0;
        bus.ex_flush  = 1'b0;
        #1;
        check_eq("rst_pc_ifid", {bus.pc_write, bus.ifid_write}, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_eq("rst_outputs",
                     {bus.pc_write, bus.ifid_write, bus.ex_alu_op, bus.ex_alu_src_imm, bus.ex_branch,
                      bus.ex_rd, bus.mem_read, bus.mem_write, bus.mem_rd, bus.wb_reg_write,
                      bus.wb_mem_to_reg, bus.wb_rd, bus.illegal_op, bus.halted}, 32'd0);
        end
        rst_n   = 1'b1;
        m_state = 0;
        m_cnt   = 0;
        m_ill   = 1'b0;
        m_ex    = '0;
        ex_q.delete();
        mem_q.delete();
        wb_q.delete();
        mem_q.push_back('0);
        wb_q.push_back('0);
        wb_q.push_back('0);
        $display("reset applied");
    endtask

    logic st;
    int   edges;

    initial begin
        do_reset();

        // Basic ADD through all stages, then drain with idle slots.
        step(1'b1, 4'd0, 3'd3, 3'd1, 3'd2, 1'b0, st);
        repeat (2) step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, st);

        // Load-use: LW r2 then ADD reading r2 stalls once, then re-issues.
        step(1'b1, 4'd7, 3'd2, 3'd1, 3'd0, 1'b0, st);
        step(1'b1, 4'd0, 3'd4, 3'd2, 3'd3, 1'b0, st);
        step(1'b1, 4'd0, 3'd4, 3'd2, 3'd3, 1'b0, st);
        repeat (2) step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, st);

        // Load into r0 is never a hazard source.
        step(1'b1, 4'd7, 3'd0, 3'd1, 3'd0, 1'b0, st);
        step(1'b1, 4'd0, 3'd5, 3'd0, 3'd0, 1'b0, st);

        // Flush coincident with a load-use stall wins.
        step(1'b1, 4'd7, 3'd2, 3'd1, 3'd0, 1'b0, st);
        step(1'b1, 4'd1, 3'd6, 3'd3, 3'd2, 1'b1, st);
        repeat (2) step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, st);

        // Random legal traffic with occasional flushes; re-issue after a stall.
        for (int i = 0; i < 30; i++) begin
            logic [3:0] op;
            logic [2:0] rd, r1, r2;
            logic       fl;
            op = 4'($urandom_range(0, 9));
            rd = 3'($urandom_range(0, 7));
            r1 = 3'($urandom_range(0, 3));
            r2 = 3'($urandom_range(0, 3));
            fl = ($urandom_range(0, 7) == 0);
            step(1'b1, op, rd, r1, r2, fl, st);
            if (st) step(1'b1, op, rd, r1, r2, 1'b0, st);
        end

        // Illegal opcode is sticky and produces a bubble.
        step(1'b1, 4'd12, 3'd3, 3'd1, 3'd1, 1'b0, st);
        step(1'b1, 4'd2, 3'd1, 3'd1, 3'd1, 1'b0, st);
        repeat (2) step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, st);

        // HALT killed by a flush does not start draining.
        step(1'b1, 4'd15, 3'd0, 3'd0, 3'd0, 1'b1, st);
        repeat (5) step(1'b1, 4'd3, 3'd7, 3'd1, 3'd1, 1'b0, st);

        // HALT accepted: halted on the fourth edge counting the accept edge.
        step(1'b1, 4'd15, 3'd0, 3'd0, 3'd0, 1'b0, st);
        edges = 1;
        while (!bus.halted && edges < 10) begin
            step(1'b1, 4'd0, 3'd1, 3'd1, 3'd1, (edges == 1), st);
            edges++;
        end
        check_eq("halt_edges", edges, 32'd4);
        repeat (3) step(1'b1, 4'd0, 3'd1, 3'd1, 3'd1, 1'b0, st);

        // Reset during DRAIN returns to RUN.
        do_reset();
        step(1'b1, 4'd15, 3'd0, 3'd0, 3'd0, 1'b0, st);
        step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, st);
        do_reset();
        step(1'b1, 4'd6, 3'd5, 3'd2, 3'd0, 1'b0, st);
        repeat (4) step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, st);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
